// File: rtl/instr_imm_encoder_pkg.sv
// instr_imm_encoder_pkg: ImmSrc format codes and FIFO sizing shared with the datapath immediate generator.
package instr_imm_encoder_pkg;
  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;
  localparam logic [1:0] FMT_J = 2'b11;
  localparam int FIFO_DEPTH = 2;
  localparam int PAYLOAD_W = 33;
endpackage

// File: rtl/instr_fifo2.sv
// instr_fifo2: two-entry FIFO with 1-bit wrapping pointers; caller gates push/pop against full/empty.
module instr_fifo2
  import instr_imm_encoder_pkg::*;
#(
  parameter int W = PAYLOAD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic wp, rp;
  logic [1:0] cnt;
  assign full  = cnt == 2'(FIFO_DEPTH);
  assign empty = cnt == 2'd0;
  assign dout  = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem <= '{default: '0};
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/instr_imm_encoder.sv
// instr_imm_encoder: packs a signed immediate into I/S/B/J instruction fields, flags unrepresentable values, buffers results.
module instr_imm_encoder
  import instr_imm_encoder_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] Imm,
  input  logic [31:0] Fields,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Instr,
  output logic        ImmErr,
  output logic [7:0]  ErrCnt
);
  logic [31:0] word;
  logic err, push, pop, full, empty;
  always_comb begin
    word = Fields;
    err  = 1'b0;
    case (ImmSrc)
      FMT_I: begin
        word[31:20] = Imm[11:0];
        err = Imm[31:11] != {21{Imm[31]}};
      end
      FMT_S: begin
        word[31:25] = Imm[11:5];
        word[11:7]  = Imm[4:0];
        err = Imm[31:11] != {21{Imm[31]}};
      end
      FMT_B: begin
        word[31:25] = {Imm[12], Imm[10:5]};
        word[11:7]  = {Imm[4:1], Imm[11]};
        err = (Imm[31:12] != {20{Imm[31]}}) || Imm[0];
      end
      default: begin
        word[31:12] = {Imm[20], Imm[10:1], Imm[11], Imm[19:12]};
        err = (Imm[31:20] != {12{Imm[31]}}) || Imm[0];
      end
    endcase
  end
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign in_ready  = !full || pop;
  assign push      = in_valid && in_ready;
  instr_fifo2 #(.W(PAYLOAD_W)) u_fifo (
    .clk  (CLK),
    .rst_n(RST),
    .push (push),
    .pop  (pop),
    .din  ({err, word}),
    .dout ({ImmErr, Instr}),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge CLK or negedge RST)
    if (!RST) ErrCnt <= 8'd0;
    else if (push && err && ErrCnt != 8'hFF) ErrCnt <= ErrCnt + 8'd1;
endmodule
